multi_channel_interval_timer: RTL

- Parametrised successor to the team's single-channel 16-bit-bus interval timer.
- Provides NUM_CH independent down-counting timers of CNT_W bits, each with:
  - an 8-bit programmable prescaler
  - a compare register with its own interrupt source and PWM output
  - a one-shot or continuous mode
  - a snapshot register
- Memory-mapped Avalon-MM slave (DATA_W bus, fixed 1-cycle read latency). Sits next to the CPU as the system tick/profiling/PWM source.

---
 rtl/multi_channel_interval_timer.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/multi_channel_interval_timer.sv
// Multi-channel interval timer: NUM_CH independent prescaled down-counters with
// compare/PWM, one-shot or continuous reload, snapshot, behind an Avalon-MM slave.
module multi_channel_interval_timer #(
    parameter int          NUM_CH       = 4,
    parameter int          CNT_W        = 32,
    parameter int          DATA_W       = 32,
    parameter int          PRESCALE_W   = 8,
    parameter int unsigned RESET_PERIOD = 49
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [$clog2(NUM_CH)+2:0]  address,
    input  logic                       chipselect,
    input  logic                       write_n,
    input  logic [DATA_W-1:0]          writedata,
    output logic [DATA_W-1:0]          readdata,
    output logic [NUM_CH-1:0]          irq,
    output logic                       irq_any,
    output logic [NUM_CH-1:0]          pwm_out
);

    localparam int ADDR_W = $clog2(NUM_CH) + 3;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(RESET_PERIOD);

    logic [2:0]                    offset;
    logic [CH_W-1:0]               sel_ch;
    logic                          sel_valid;
    logic                          bus_write;
    logic [NUM_CH-1:0][DATA_W-1:0] ch_rdata;
    logic [DATA_W-1:0]             rd_mux;

    assign offset = address[2:0];

    generate
        if (NUM_CH > 1) begin : g_sel
            assign sel_ch = address[ADDR_W-1:3];
        end else begin : g_sel_single
            assign sel_ch = '0;
        end
    endgenerate

    // Channel indices past NUM_CH (non-power-of-two counts) are dead space.
    assign sel_valid = ({1'b0, sel_ch} < (CH_W + 1)'(NUM_CH));
    assign bus_write = chipselect && !write_n && sel_valid;

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            logic                  wr_sel;
            logic                  wr_status;
            logic                  wr_control;
            logic                  wr_period;
            logic                  wr_compare;
            logic                  wr_snap;
            logic                  wr_prescale;
            logic                  start;
            logic                  stop;
            logic                  tick;
            logic                  at_zero;
            logic                  to_set;
            logic                  cmpf_set;
            logic [CNT_W-1:0]      tick_count;

            logic [CNT_W-1:0]      count;
            logic [CNT_W-1:0]      count_next;
            logic [PRESCALE_W-1:0] ps;
            logic [PRESCALE_W-1:0] ps_next;
            logic                  run;
            logic                  run_next;
            logic                  to_flag;
            logic                  to_next;
            logic                  cmpf;
            logic                  cmpf_next;

            logic [CNT_W-1:0]      period;
            logic [CNT_W-1:0]      compare;
            logic [CNT_W-1:0]      snap;
            logic [PRESCALE_W-1:0] prescale;
            logic                  ito;
            logic                  cont;
            logic                  icmp;
            logic                  pwm;
            logic [DATA_W-1:0]     rd;

            assign wr_sel      = bus_write && (sel_ch == CH_W'(c));
            assign wr_status   = wr_sel && (offset == 3'd0);
            assign wr_control  = wr_sel && (offset == 3'd1);
            assign wr_period   = wr_sel && (offset == 3'd2);
            assign wr_compare  = wr_sel && (offset == 3'd3);
            assign wr_snap     = wr_sel && (offset == 3'd4);
            assign wr_prescale = wr_sel && (offset == 3'd5);

            assign start = wr_control && writedata[2];
            assign stop  = wr_control && writedata[3];

            assign tick       = run && (ps == prescale);
            assign at_zero    = (count == '0);
            assign tick_count = at_zero ? period : (count - CNT_W'(1));
            assign to_set     = tick && at_zero;
            // Covers both the decrement landing on COMPARE and a reload to PERIOD==COMPARE.
            assign cmpf_set   = tick && (tick_count == compare);

            always_comb begin
                ps_next    = ps + PRESCALE_W'(1);
                count_next = count;
                run_next   = run;
                to_next    = to_flag;
                cmpf_next  = cmpf;

                if (wr_period || start || !run || tick) begin
                    ps_next = '0;
                end

                if (wr_period) begin
                    count_next = writedata[CNT_W-1:0];
                end else if (tick) begin
                    count_next = tick_count;
                end

                // START outranks STOP; a PERIOD write always parks the channel.
                if (wr_period) begin
                    run_next = 1'b0;
                end else if (start) begin
                    run_next = 1'b1;
                end else if (stop) begin
                    run_next = 1'b0;
                end else if (to_set && !cont) begin
                    run_next = 1'b0;
                end

                // A hardware set in the same cycle as a W1C clear wins.
                if (to_set) begin
                    to_next = 1'b1;
                end else if (wr_status && writedata[0]) begin
                    to_next = 1'b0;
                end

                if (cmpf_set) begin
                    cmpf_next = 1'b1;
                end else if (wr_status && writedata[2]) begin
                    cmpf_next = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    count   <= RST_VAL;
                    ps      <= '0;
                    run     <= 1'b0;
                    to_flag <= 1'b0;
                    cmpf    <= 1'b0;
                    pwm     <= 1'b0;
                end else begin
                    count   <= count_next;
                    ps      <= ps_next;
                    run     <= run_next;
                    to_flag <= to_next;
                    cmpf    <= cmpf_next;
                    pwm     <= run && (count < compare);
                end
            end

            // SNAP samples the pre-edge COUNT, so a capture on a tick edge sees the old value.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    period   <= RST_VAL;
                    compare  <= '0;
                    snap     <= '0;
                    prescale <= '0;
                    ito      <= 1'b0;
                    cont     <= 1'b0;
                    icmp     <= 1'b0;
                end else begin
                    if (wr_period) begin
                        period <= writedata[CNT_W-1:0];
                    end
                    if (wr_compare) begin
                        compare <= writedata[CNT_W-1:0];
                    end
                    if (wr_snap) begin
                        snap <= count;
                    end
                    if (wr_prescale) begin
                        prescale <= writedata[PRESCALE_W-1:0];
                    end
                    if (wr_control) begin
                        ito  <= writedata[0];
                        cont <= writedata[1];
                        icmp <= writedata[4];
                    end
                end
            end

            always_comb begin
                rd = '0;
                case (offset)
                    3'd0:    rd[2:0]            = {cmpf, run, to_flag};
                    3'd1:    rd[4:0]            = {icmp, 2'b00, cont, ito};
                    3'd2:    rd[CNT_W-1:0]      = period;
                    3'd3:    rd[CNT_W-1:0]      = compare;
                    3'd4:    rd[CNT_W-1:0]      = snap;
                    3'd5:    rd[PRESCALE_W-1:0] = prescale;
                    3'd6:    rd[CNT_W-1:0]      = count;
                    default: rd                 = '0;
                endcase
            end

            assign ch_rdata[c] = rd;
            assign irq[c]      = (to_flag && ito) || (cmpf && icmp);
            assign pwm_out[c]  = pwm;
        end
    endgenerate

    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (sel_valid && (sel_ch == CH_W'(c))) begin
                rd_mux = ch_rdata[c];
            end
        end
    end

    // Read data is registered every cycle regardless of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

    assign irq_any = |irq;

endmodule
